fp_expand_decoder: RTL and testbench

Multi-cycle decoder that rebuilds a 12-bit two's-complement linear sample from the compressed floating-point triple: sign S, 3-bit exponent E, 4-bit significand F. It is the receive-side counterpart of the linear-to-float encoder path (sign/magnitude, leading-bit extraction, rounding). It accepts one code per valid/ready transfer, expands it with an iterative one-bit-per-cycle shifter, applies the sign, and holds the result until the consumer takes it.

---
 rtl/fp_expand_decoder.sv | 129 ++++++++++++
 tb/tb_fp_expand_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fp_expand_decoder.sv
// Iterative float-to-linear expander: S/E/F code in, OUT_W-bit two's-complement sample out.
// Optional midpoint reconstruction is enabled with `define FP_DECODE_MIDPOINT_EN.
module fp_expand_decoder #(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned SIG_W = 4,
  parameter int unsigned OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [SIG_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D
);

  localparam int unsigned MAG_W = OUT_W - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    NEGATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sign;
  logic             w_sign_nxt;
  logic [MAG_W-1:0] r_mag;
  logic [MAG_W-1:0] w_mag_nxt;
  logic [EXP_W-1:0] r_cnt;
  logic [EXP_W-1:0] w_cnt_nxt;
  logic [OUT_W-1:0] r_d;
  logic [OUT_W-1:0] w_d_nxt;
  logic             r_out_valid;
  logic             w_out_valid_nxt;
  logic [MAG_W-1:0] w_m;

`ifdef FP_DECODE_MIDPOINT_EN
  logic [EXP_W-1:0] r_exp;
  logic [MAG_W-1:0] w_rnd;

  // Original exponent is kept because r_cnt is consumed by the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_exp <= E;
    end
  end

  // A zero magnitude means F was zero, so no midpoint offset is added.
  assign w_rnd = (r_exp != '0 && r_mag != '0) ?
                 (MAG_W'(1) << (r_exp - EXP_W'(1))) : '0;
  assign w_m   = r_mag + w_rnd;
`else
  assign w_m   = r_mag;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign D         = r_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_d         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sign      <= w_sign_nxt;
      r_mag       <= w_mag_nxt;
      r_cnt       <= w_cnt_nxt;
      r_d         <= w_d_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sign_nxt      = r_sign;
    w_mag_nxt       = r_mag;
    w_cnt_nxt       = r_cnt;
    w_d_nxt         = r_d;
    w_out_valid_nxt = r_out_valid;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sign_nxt  = S;
          w_mag_nxt   = MAG_W'(F);
          w_cnt_nxt   = E;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_mag_nxt = r_mag << 1;
          w_cnt_nxt = r_cnt - EXP_W'(1);
        end else begin
          w_state_nxt = NEGATE;
        end
      end
      NEGATE: begin
        // Magnitude fits in MAG_W bits, so negation never overflows.
        w_d_nxt         = r_sign ? (OUT_W'(0) - {1'b0, w_m}) : {1'b0, w_m};
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_expand_decoder.sv
// Directed bench for fp_expand_decoder; expected values follow FP_DECODE_MIDPOINT_EN when defined.
module tb_fp_expand_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [11:0] d_trunc;
    logic [11:0] d_mid;
  } vec_t;

  vec_t vecs[11];

  fp_expand_decoder #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .S        (S),
    .E        (E),
    .F        (F),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [11:0] pick(input vec_t v);
`ifdef FP_DECODE_MIDPOINT_EN
    return v.d_mid;
`else
    return v.d_trunc;
`endif
  endfunction

  // Accept one code, then wait (bounded) for out_valid and check latency and D.
  task automatic send_and_wait(input logic s, input logic [2:0] e, input logic [3:0] f,
                               input logic [11:0] req_d, input string nm);
    int cycles;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    S = s; E = e; F = f; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      cycles++;
      #1;
      if (out_valid) break;
    end
    check({nm, "_latency"}, 32'(cycles), 32'(e) + 32'd2);
    check({nm, "_D"}, 32'(D), 32'(req_d));
    check({nm, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    S = 1'b0; E = '0; F = '0;

    vecs[0]  = '{1'b0, 3'd0, 4'b0101, 12'h005, 12'h005};
    vecs[1]  = '{1'b0, 3'd3, 4'b1101, 12'h068, 12'h06C};
    vecs[2]  = '{1'b1, 3'd7, 4'b1111, 12'h880, 12'h840};
    vecs[3]  = '{1'b1, 3'd0, 4'b0000, 12'h000, 12'h000};
    vecs[4]  = '{1'b1, 3'd5, 4'b0000, 12'h000, 12'h000};
    vecs[5]  = '{1'b0, 3'd1, 4'b1000, 12'h010, 12'h011};
    vecs[6]  = '{1'b0, 3'd2, 4'b1001, 12'h024, 12'h026};
    vecs[7]  = '{1'b1, 3'd2, 4'b0011, 12'hFF4, 12'hFF2};
    vecs[8]  = '{1'b0, 3'd7, 4'b0001, 12'h080, 12'h0C0};
    vecs[9]  = '{1'b1, 3'd4, 4'b1010, 12'hF60, 12'hF58};
    vecs[10] = '{1'b0, 3'd6, 4'b1111, 12'h3C0, 12'h3E0};

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of codes with out_ready tied high.
    for (int i = 0; i < 11; i++) begin
      send_and_wait(vecs[i].s, vecs[i].e, vecs[i].f, pick(vecs[i]), $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pop_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d_pop_ready", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: hold the result while a different code is offered.
    out_ready = 1'b0;
    send_and_wait(1'b0, 3'd1, 4'b1000, pick(vecs[5]), "bp");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = c[0] ? 1'b0 : 1'b1;
      S = 1'b1; E = 3'd2; F = 4'b0011;
      @(posedge clk);
      #1;
      check("bp_hold_D", 32'(D), 32'(pick(vecs[5])));
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_idle_keeps_D", 32'(D), 32'(pick(vecs[5])));

    // Reset during the third SHIFT cycle of an E=6 code.
    @(negedge clk);
    S = 1'b0; E = 3'd6; F = 4'b1111; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_D", 32'(D), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_and_wait(1'b0, 3'd2, 4'b1001, pick(vecs[6]), "post_rst");
    @(posedge clk);
    #1;
    check("post_rst_pop", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
